// File: rtl/iddr_deser_pkg.sv
// Shared constants and sizing helpers for the DDR input deserialiser.
package iddr_deser_pkg;

  localparam int MAX_RATIO = 8;
  localparam int OFF_W     = $clog2(MAX_RATIO);

  function automatic int ratio_clog2(input int ratio);
    return $clog2(ratio);
  endfunction

endpackage

// File: rtl/iddr_capture.sv
// Dual-edge capture of DDR data, re-timed into a posedge-aligned rise/fall pair.
// This is the only block to swap for a vendor IDDR primitive.
module iddr_capture
  import iddr_deser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] pair_rise,
  output logic [WIDTH-1:0] pair_fall
);

  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_reg  <= '0;
      pair_rise <= '0;
      pair_fall <= '0;
    end else begin
      rise_reg  <= d;
      // rise_reg still holds the previous posedge sample here, matching fall_reg
      pair_rise <= rise_reg;
      pair_fall <= fall_reg;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fall_reg <= '0;
    end else begin
      fall_reg <= d;
    end
  end

endmodule

// File: rtl/iddr_deser.sv
// DDR deserialiser with bitslip word alignment.
// Optional: define IDDR_DESER_SLIP_COUNT_EN to build the saturating slip counter.
module iddr_deser
  import iddr_deser_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       d,
  input  logic                   bitslip,
  output logic [WIDTH*RATIO-1:0] q,
  output logic                   q_valid,
  output logic                   slip_pending,
  output logic [7:0]             slip_cnt
);

  localparam int HIST  = 2 * RATIO;
  localparam int PH_W  = (ratio_clog2(RATIO) > 1) ? ratio_clog2(RATIO) - 1 : 1;
  localparam int IDX_W = ratio_clog2(HIST);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(RATIO / 2 - 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(RATIO - 1);

  logic [WIDTH-1:0]       pair_rise;
  logic [WIDTH-1:0]       pair_fall;
  logic [WIDTH-1:0]       hist_reg [HIST-2];
  logic [WIDTH-1:0]       hist_w   [HIST];
  logic [PH_W-1:0]        ph_reg;
  logic [OFF_W-1:0]       off_reg;
  logic [OFF_W-1:0]       off_next;
  logic [OFF_W-1:0]       sh;
  logic                   slip_pending_reg;
  logic                   primed_reg;
  logic [WIDTH*RATIO-1:0] q_reg;
  logic                   q_valid_reg;
  logic [WIDTH*RATIO-1:0] word_next;
  logic                   boundary;
  logic                   accept;
  logic                   apply;
  logic                   wrap;
  logic                   emit;

  iddr_capture #(
    .WIDTH(WIDTH)
  ) u_capture (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .pair_rise(pair_rise),
    .pair_fall(pair_fall)
  );

  // hist_w[0] is the newest sample; the pair register forms the two youngest slots
  genvar gi;
  generate
    for (gi = 0; gi < HIST; gi++) begin : g_hist
      if (gi == 0) begin : g_fall
        assign hist_w[gi] = pair_fall;
      end else if (gi == 1) begin : g_rise
        assign hist_w[gi] = pair_rise;
      end else begin : g_old
        assign hist_w[gi] = hist_reg[gi-2];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST - 2; i++) begin
        hist_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < HIST - 2; i++) begin
        hist_reg[i] <= hist_w[i];
      end
    end
  end

  assign boundary = (ph_reg == PH_LAST);
  assign accept   = bitslip & ~slip_pending_reg;
  assign apply    = boundary & slip_pending_reg;
  assign wrap     = apply & (off_reg == OFF_LAST);
  assign emit     = boundary & primed_reg & ~wrap;

  always_comb begin
    off_next = off_reg;
    if (apply) begin
      off_next = wrap ? '0 : off_reg + OFF_W'(1);
    end
  end

  // Each slip moves the word one sample later in the stream; since only the
  // current word is available, that window sits (RATIO - off) samples back.
  always_comb begin
    sh = '0;
    if (off_next != '0) begin
      sh = OFF_W'(RATIO) - off_next;
    end
  end

  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      logic [IDX_W-1:0] idx;
      assign idx = IDX_W'(RATIO - 1 - gi) + IDX_W'(sh);
      assign word_next[gi*WIDTH +: WIDTH] = hist_w[idx];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_reg           <= '0;
      off_reg          <= '0;
      slip_pending_reg <= 1'b0;
      primed_reg       <= 1'b0;
      q_reg            <= '0;
      q_valid_reg      <= 1'b0;
    end else begin
      ph_reg           <= boundary ? '0 : ph_reg + PH_W'(1);
      off_reg          <= off_next;
      slip_pending_reg <= accept | (slip_pending_reg & ~boundary);
      if (boundary) begin
        primed_reg <= 1'b1;
      end
      q_valid_reg <= emit;
      if (emit) begin
        q_reg <= word_next;
      end
    end
  end

`ifdef IDDR_DESER_SLIP_COUNT_EN
  logic [7:0] slip_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slip_cnt_reg <= '0;
    end else if (accept && (slip_cnt_reg != 8'hFF)) begin
      slip_cnt_reg <= slip_cnt_reg + 8'd1;
    end
  end

  assign slip_cnt = slip_cnt_reg;
`else
  assign slip_cnt = 8'd0;
`endif

  assign q            = q_reg;
  assign q_valid      = q_valid_reg;
  assign slip_pending = slip_pending_reg;

endmodule

// File: tb/tb_iddr_deser.sv
// Directed bench: a 1-lane x4 instance with bitslip traffic and an 8-lane x8
// instance on an incrementing byte stream, sharing clock and reset.
`timescale 1ns/1ps
module tb_iddr_deser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:0]  d_a;
  logic [7:0]  d_b;
  logic        bitslip_a;
  logic        bitslip_b;
  logic [3:0]  q_a;
  logic [63:0] q_b;
  logic        q_valid_a, q_valid_b;
  logic        slip_pending_a, slip_pending_b;
  logic [7:0]  slip_cnt_a, slip_cnt_b;

  int tests_run    = 0;
  int tests_failed = 0;
  int n = 0;   // index of the posedge about to capture
  int e = -1;  // index of the last posedge since reset release
  int vcnt = 0;

`ifdef IDDR_DESER_SLIP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  iddr_deser #(.WIDTH(1), .RATIO(4)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .d           (d_a),
    .bitslip     (bitslip_a),
    .q           (q_a),
    .q_valid     (q_valid_a),
    .slip_pending(slip_pending_a),
    .slip_cnt    (slip_cnt_a)
  );

  iddr_deser #(.WIDTH(8), .RATIO(8)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .d           (d_b),
    .bitslip     (bitslip_b),
    .q           (q_b),
    .q_valid     (q_valid_b),
    .slip_pending(slip_pending_b),
    .slip_cnt    (slip_cnt_b)
  );

  function automatic logic pat(input int i);
    return (i % 4) == 0;
  endfunction

  function automatic logic [63:0] bytes_from(input int base);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[8*j +: 8] = 8'(base + j);
    return v;
  endfunction

  function automatic logic [7:0] cnt_exp(input int k);
    return CNT_EN ? 8'(k) : 8'd0;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, e);
    end else begin
      $display("ok   %s: 0x%0h (edge %0d)", tag, got, e);
    end
  endtask

  // One clock: bs is presented to the coming posedge; returns just after the negedge.
  task automatic tick(input logic bs);
    bitslip_a = bs;
    @(posedge clk);
    #2;
    bitslip_a = 1'b0;
    d_a = pat(2*n + 1);
    d_b = 8'(2*n + 1);
    @(negedge clk);
    #2;
    n++;
    d_a = pat(2*n);
    d_b = 8'(2*n);
    e++;
    if (q_valid_a) vcnt++;
  endtask

  task automatic run_to(input int target);
    while (e < target) tick(1'b0);
  endtask

  task automatic release_reset();
    n = 0;
    e = -1;
    d_a = pat(0);
    d_b = 8'd0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bitslip_a = 1'b0;
    bitslip_b = 1'b0;
    d_a = 1'b0;
    d_b = 8'd0;
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_q_a", q_a, 0);
    check_eq("rst_valid_a", q_valid_a, 0);
    check_eq("rst_pend_a", slip_pending_a, 0);
    check_eq("rst_cnt_a", slip_cnt_a, 0);
    check_eq("rst_q_b", q_b, 0);
    check_eq("rst_valid_b", q_valid_b, 0);

    release_reset();
    run_to(1);
    check_eq("fill_valid_a", q_valid_a, 0);
    run_to(3);
    check_eq("first_valid_a", q_valid_a, 1);
    check_eq("first_q_a", q_a, 4'b0001);
    check_eq("fill_valid_b", q_valid_b, 0);
    run_to(4);
    check_eq("strobe_low_a", q_valid_a, 0);
    check_eq("hold_q_a", q_a, 4'b0001);
    run_to(5);
    check_eq("valid_e5_a", q_valid_a, 1);
    check_eq("q_e5_a", q_a, 4'b0001);

    // first slip: off 0 -> 1
    tick(1'b1);
    check_eq("slip1_pending", slip_pending_a, 1);
    tick(1'b0);
    check_eq("slip1_pend_clr", slip_pending_a, 0);
    check_eq("slip1_valid", q_valid_a, 1);
    check_eq("slip1_q", q_a, 4'b1000);
    check_eq("slip1_cnt", slip_cnt_a, cnt_exp(1));
    check_eq("first_valid_b", q_valid_b, 1);
    check_eq("first_q_b", q_b, bytes_from(4));
    tick(1'b0);
    check_eq("strobe_low_b", q_valid_b, 0);

    // second slip, then a repeat on the next cycle that must be ignored
    run_to(9);
    tick(1'b1);
    tick(1'b1);
    check_eq("slip2_repeat_ignored", slip_pending_a, 0);
    check_eq("slip2_q", q_a, 4'b0100);
    check_eq("slip2_cnt", slip_cnt_a, cnt_exp(2));
    check_eq("second_q_b", q_b, bytes_from(12));
    check_eq("second_valid_b", q_valid_b, 1);

    // third slip: off 2 -> 3
    run_to(13);
    tick(1'b1);
    tick(1'b0);
    check_eq("slip3_q", q_a, 4'b0010);
    check_eq("slip3_cnt", slip_cnt_a, cnt_exp(3));

    // fourth slip wraps off 3 -> 0 and drops one strobe
    run_to(15);
    vcnt = 0;
    run_to(17);
    check_eq("off3_steady_q", q_a, 4'b0010);
    tick(1'b1);
    tick(1'b0);
    check_eq("wrap_drop_valid", q_valid_a, 0);
    check_eq("wrap_hold_q", q_a, 4'b0010);
    run_to(21);
    check_eq("wrap_after_valid", q_valid_a, 1);
    check_eq("wrap_after_q", q_a, 4'b0001);
    check_eq("wrap_cnt", slip_cnt_a, cnt_exp(4));
    check_eq("wrap_strobe_count", vcnt, 2);

    // slip coincident with a boundary is deferred to the next one
    run_to(22);
    tick(1'b1);
    check_eq("bnd_slip_valid", q_valid_a, 1);
    check_eq("bnd_slip_q_unchanged", q_a, 4'b0001);
    check_eq("bnd_slip_pending", slip_pending_a, 1);
    tick(1'b0);
    check_eq("bnd_slip_still_pending", slip_pending_a, 1);
    tick(1'b0);
    check_eq("bnd_slip_applied_q", q_a, 4'b1000);
    check_eq("bnd_slip_pend_clr", slip_pending_a, 0);
    check_eq("bnd_slip_cnt", slip_cnt_a, cnt_exp(5));

    // asynchronous reset while a slip is pending
    tick(1'b1);
    check_eq("pre_rst_pending", slip_pending_a, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_q_a", q_a, 0);
    check_eq("async_rst_valid_a", q_valid_a, 0);
    check_eq("async_rst_pend_a", slip_pending_a, 0);
    check_eq("async_rst_cnt_a", slip_cnt_a, 0);
    check_eq("async_rst_q_b", q_b, 0);
    @(negedge clk);
    #2;
    release_reset();
    run_to(1);
    check_eq("refill_valid_a", q_valid_a, 0);
    run_to(3);
    check_eq("refill_first_valid_a", q_valid_a, 1);
    check_eq("refill_q_a", q_a, 4'b0001);
    check_eq("refill_pend_a", slip_pending_a, 0);
    run_to(7);
    check_eq("refill_valid_b", q_valid_b, 1);
    check_eq("refill_q_b", q_b, bytes_from(4));
    check_eq("cnt_b_zero", slip_cnt_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
